// File: rtl/rom_load_ctrl_if.sv
// Bundles the loader, CPU-read and ROM-port signals of rom_load_ctrl.
// slave: the controller's view; master: the surrounding system (data_io, CPU, ROM, status sinks).
// Pure wiring, no state.
interface rom_load_ctrl_if #(
    parameter int ROM_AW = 14
);
    logic              dio_download;
    logic              dio_write;
    logic [24:0]       dio_addr;
    logic [7:0]        dio_data;
    logic              cpu_mreq_n;
    logic              cpu_rd_n;
    logic [15:0]       cpu_addr;
    logic [ROM_AW-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              mem_wren;
    logic              mem_rden;
    logic              cpu_reset_req;
    logic              rom_loaded;
    logic              load_error;
    logic [15:0]       byte_count;
    logic [7:0]        rom_checksum;

    modport slave (
        input  dio_download, dio_write, dio_addr, dio_data,
        input  cpu_mreq_n, cpu_rd_n, cpu_addr,
        output mem_addr, mem_din, mem_wren, mem_rden,
        output cpu_reset_req, rom_loaded, load_error, byte_count, rom_checksum
    );

    modport master (
        output dio_download, dio_write, dio_addr, dio_data,
        output cpu_mreq_n, cpu_rd_n, cpu_addr,
        input  mem_addr, mem_din, mem_wren, mem_rden,
        input  cpu_reset_req, rom_loaded, load_error, byte_count, rom_checksum
    );
endinterface

// File: rtl/rom_load_ctrl.sv
// Shares the ROM write port between the data_io download stream and CPU reads; sequences CPU reset.
// Latency: download writes reach the ROM 1 cycle after their strobe; CPU reads are combinational.
// No backpressure: every in-range strobe during a load is written, one per cycle.
module rom_load_ctrl #(
    parameter int ROM_AW       = 14,
    parameter int ROM_SIZE     = 12288,
    parameter int HOLD_CYCLES  = 256,
    parameter bit REQUIRE_LOAD = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    rom_load_ctrl_if.slave  bus
);
    localparam int HCW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        HOLD  = 3'd3,
        RUN   = 3'd4
    } state_t;

    state_t            state;
    logic [HCW-1:0]    hold_cnt;
    logic              wr_vld;
    logic [ROM_AW-1:0] wr_addr;
    logic [7:0]        wr_dat;
    logic              rom_loaded;
    logic              load_error;
    logic              cpu_reset_req;
    logic [15:0]       byte_count;
    logic [7:0]        rom_checksum;

    logic in_range;
    logic start_load;
    logic loader_owns;
    logic cpu_owns;
    logic unused_cpu_addr_hi;

    assign in_range    = bus.dio_addr < 25'(ROM_SIZE);
    // A new download preempts any non-loading state, including an in-progress hold count.
    assign start_load  = bus.dio_download && (state == IDLE || state == RUN || state == HOLD);
    assign loader_owns = (state == LOAD) || (state == DRAIN);
    assign cpu_owns    = (state == IDLE) || (state == RUN);
    // Upper CPU address bits lie outside the ROM window and are deliberately ignored.
    assign unused_cpu_addr_hi = ^bus.cpu_addr[15:ROM_AW];

    // Controller FSM, write stage, statistics and registered CPU reset request.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            wr_vld        <= 1'b0;
            wr_addr       <= '0;
            wr_dat        <= '0;
            rom_loaded    <= 1'b0;
            load_error    <= 1'b0;
            byte_count    <= '0;
            rom_checksum  <= '0;
            cpu_reset_req <= REQUIRE_LOAD;
        end else begin
            wr_vld <= 1'b0;
            if (start_load) begin
                state         <= LOAD;
                byte_count    <= '0;
                rom_checksum  <= '0;
                load_error    <= 1'b0;
                rom_loaded    <= 1'b0;
                cpu_reset_req <= 1'b1;
            end else begin
                case (state)
                    LOAD: begin
                        // A strobe in the same cycle download falls is still captured here.
                        if (bus.dio_write) begin
                            if (in_range) begin
                                wr_vld       <= 1'b1;
                                wr_addr      <= bus.dio_addr[ROM_AW-1:0];
                                wr_dat       <= bus.dio_data;
                                rom_checksum <= rom_checksum + bus.dio_data;
                                if (byte_count != 16'hFFFF)
                                    byte_count <= byte_count + 16'd1;
                            end else begin
                                load_error <= 1'b1;
                            end
                        end
                        if (!bus.dio_download)
                            state <= DRAIN;
                    end
                    DRAIN: begin
                        state      <= HOLD;
                        hold_cnt   <= '0;
                        rom_loaded <= !load_error;
                    end
                    HOLD: begin
                        if (hold_cnt == HCW'(HOLD_CYCLES - 1)) begin
                            if (load_error) begin
                                state         <= IDLE;
                                cpu_reset_req <= REQUIRE_LOAD && !rom_loaded;
                            end else begin
                                state         <= RUN;
                                cpu_reset_req <= 1'b0;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + HCW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ROM port mux: loader's write stage during LOAD/DRAIN, CPU read path otherwise.
    always_comb begin
        bus.mem_addr = loader_owns ? wr_addr : bus.cpu_addr[ROM_AW-1:0];
        bus.mem_din  = wr_dat;
        bus.mem_wren = wr_vld;
        bus.mem_rden = cpu_owns && !bus.cpu_mreq_n && !bus.cpu_rd_n;
    end

    assign bus.cpu_reset_req = cpu_reset_req;
    assign bus.rom_loaded    = rom_loaded;
    assign bus.load_error    = load_error;
    assign bus.byte_count    = byte_count;
    assign bus.rom_checksum  = rom_checksum;
endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed bench for rom_load_ctrl: reset hold, download/write timing, hold count, CPU reads,
// out-of-range rejection, late strobe at download end, hold re-entry and mid-load reset.
// Inputs driven 1 time unit after the rising edge; outputs sampled there as well.
module tb_rom_load_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rom_load_ctrl_if #(.ROM_AW(14)) bus ();

    rom_load_ctrl #(
        .ROM_AW(14), .ROM_SIZE(12288), .HOLD_CYCLES(256), .REQUIRE_LOAD(1'b1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_release(output int n);
        n = 0;
        while (bus.cpu_reset_req === 1'b1 && n < 1000) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        bit bad = 0;
        checks++; if (bus.byte_count !== 16'd0) begin errors++; $display("FAIL reset_byte_count got %h want 0000", bus.byte_count); end
        checks++; if (bus.rom_checksum !== 8'd0) begin errors++; $display("FAIL reset_checksum got %h want 00", bus.rom_checksum); end
        checks++; if (bus.load_error !== 1'b0) begin errors++; $display("FAIL reset_load_error got %b want 0", bus.load_error); end
        for (int i = 0; i < 50; i++) begin
            if (bus.cpu_reset_req !== 1'b1 || bus.rom_loaded !== 1'b0 || bus.mem_wren !== 1'b0) bad = 1;
            tick();
        end
        checks++; if (bad) begin errors++; $display("FAIL reset_idle_hold got req/loaded/wren=%b%b%b want 100", bus.cpu_reset_req, bus.rom_loaded, bus.mem_wren); end
    endtask

    task automatic test_back_to_back();
        logic [24:0] a [3] = '{25'd0, 25'd1, 25'd2};
        logic [7:0]  d [3] = '{8'hAA, 8'h55, 8'h01};
        int n;
        bus.dio_download = 1'b1;
        tick();
        checks++; if (bus.cpu_reset_req !== 1'b1) begin errors++; $display("FAIL b2b_load_req got %b want 1", bus.cpu_reset_req); end
        for (int i = 0; i < 3; i++) begin
            bus.dio_write = 1'b1; bus.dio_addr = a[i]; bus.dio_data = d[i];
            tick();
            checks++;
            if (bus.mem_wren !== 1'b1 || bus.mem_addr !== 14'(i) || bus.mem_din !== d[i] || bus.byte_count !== 16'(i + 1)) begin
                errors++;
                $display("FAIL b2b_write%0d got wren=%b addr=%h din=%h cnt=%0d want 1 %h %h %0d",
                         i, bus.mem_wren, bus.mem_addr, bus.mem_din, bus.byte_count, 14'(i), d[i], i + 1);
            end
        end
        bus.dio_write = 1'b0; bus.dio_download = 1'b0;
        tick();
        checks++; if (bus.mem_wren !== 1'b0 || bus.rom_loaded !== 1'b0) begin errors++; $display("FAIL b2b_drain got wren=%b loaded=%b want 0 0", bus.mem_wren, bus.rom_loaded); end
        checks++; if (bus.byte_count !== 16'd3 || bus.rom_checksum !== 8'h00) begin errors++; $display("FAIL b2b_stats got cnt=%0d sum=%h want 3 00", bus.byte_count, bus.rom_checksum); end
        tick();
        checks++; if (bus.rom_loaded !== 1'b1 || bus.cpu_reset_req !== 1'b1) begin errors++; $display("FAIL b2b_hold_entry got loaded=%b req=%b want 1 1", bus.rom_loaded, bus.cpu_reset_req); end
        wait_release(n);
        checks++; if (n !== 256) begin errors++; $display("FAIL b2b_hold_len got %0d want 256", n); end
    endtask

    task automatic test_cpu_read();
        bus.cpu_mreq_n = 1'b0; bus.cpu_rd_n = 1'b0; bus.cpu_addr = 16'h1234;
        #1;
        checks++; if (bus.mem_rden !== 1'b1 || bus.mem_addr !== 14'h1234 || bus.mem_wren !== 1'b0) begin errors++; $display("FAIL cpu_read got rden=%b addr=%h wren=%b want 1 1234 0", bus.mem_rden, bus.mem_addr, bus.mem_wren); end
        bus.cpu_addr = 16'hF234;
        #1;
        checks++; if (bus.mem_addr !== 14'h3234) begin errors++; $display("FAIL cpu_addr_trunc got %h want 3234", bus.mem_addr); end
        bus.cpu_mreq_n = 1'b1;
        #1;
        checks++; if (bus.mem_rden !== 1'b0) begin errors++; $display("FAIL cpu_no_mreq got rden=%b want 0", bus.mem_rden); end
        bus.cpu_rd_n = 1'b1;
        tick();
    endtask

    task automatic test_drain_write();
        bus.dio_download = 1'b1;
        tick();
        checks++; if (bus.byte_count !== 16'd0 || bus.rom_checksum !== 8'd0 || bus.rom_loaded !== 1'b0 || bus.cpu_reset_req !== 1'b1) begin errors++; $display("FAIL drain_entry got cnt=%0d sum=%h loaded=%b req=%b want 0 00 0 1", bus.byte_count, bus.rom_checksum, bus.rom_loaded, bus.cpu_reset_req); end
        bus.dio_write = 1'b1; bus.dio_addr = 25'd7; bus.dio_data = 8'h3C; bus.dio_download = 1'b0;
        tick();
        bus.dio_write = 1'b0;
        checks++; if (bus.mem_wren !== 1'b1 || bus.mem_addr !== 14'd7 || bus.mem_din !== 8'h3C) begin errors++; $display("FAIL drain_write got wren=%b addr=%h din=%h want 1 0007 3c", bus.mem_wren, bus.mem_addr, bus.mem_din); end
        checks++; if (bus.byte_count !== 16'd1 || bus.rom_checksum !== 8'h3C) begin errors++; $display("FAIL drain_stats got cnt=%0d sum=%h want 1 3c", bus.byte_count, bus.rom_checksum); end
        tick();
        checks++; if (bus.rom_loaded !== 1'b1 || bus.mem_wren !== 1'b0) begin errors++; $display("FAIL drain_hold got loaded=%b wren=%b want 1 0", bus.rom_loaded, bus.mem_wren); end
    endtask

    task automatic test_hold_reentry();
        int n;
        repeat (10) tick();
        bus.dio_download = 1'b1;
        tick();
        checks++; if (bus.byte_count !== 16'd0 || bus.rom_checksum !== 8'd0 || bus.rom_loaded !== 1'b0 || bus.cpu_reset_req !== 1'b1) begin errors++; $display("FAIL reentry_clear got cnt=%0d sum=%h loaded=%b req=%b want 0 00 0 1", bus.byte_count, bus.rom_checksum, bus.rom_loaded, bus.cpu_reset_req); end
        bus.dio_write = 1'b1; bus.dio_addr = 25'h100; bus.dio_data = 8'h80;
        tick();
        bus.dio_addr = 25'h101; bus.dio_data = 8'h90;
        tick();
        bus.dio_write = 1'b0; bus.dio_download = 1'b0;
        tick();
        tick();
        checks++; if (bus.rom_loaded !== 1'b1 || bus.byte_count !== 16'd2 || bus.rom_checksum !== 8'h10) begin errors++; $display("FAIL reentry_stats got loaded=%b cnt=%0d sum=%h want 1 2 10", bus.rom_loaded, bus.byte_count, bus.rom_checksum); end
        wait_release(n);
        checks++; if (n !== 256) begin errors++; $display("FAIL reentry_hold_len got %0d want 256", n); end
    endtask

    task automatic test_bad_addr();
        bit bad = 0;
        bus.dio_download = 1'b1;
        tick();
        bus.dio_write = 1'b1; bus.dio_addr = 25'd0; bus.dio_data = 8'h11;
        tick();
        bus.dio_addr = 25'd12288; bus.dio_data = 8'h22;
        tick();
        checks++; if (bus.mem_wren !== 1'b0 || bus.load_error !== 1'b1 || bus.byte_count !== 16'd1) begin errors++; $display("FAIL bad_drop got wren=%b err=%b cnt=%0d want 0 1 1", bus.mem_wren, bus.load_error, bus.byte_count); end
        bus.dio_addr = 25'd12287; bus.dio_data = 8'h33;
        tick();
        checks++; if (bus.mem_wren !== 1'b1 || bus.mem_addr !== 14'h2FFF || bus.mem_din !== 8'h33) begin errors++; $display("FAIL bad_last_ok got wren=%b addr=%h din=%h want 1 2fff 33", bus.mem_wren, bus.mem_addr, bus.mem_din); end
        bus.dio_write = 1'b0; bus.dio_download = 1'b0;
        tick();
        tick();
        checks++; if (bus.rom_loaded !== 1'b0 || bus.load_error !== 1'b1 || bus.rom_checksum !== 8'h44 || bus.byte_count !== 16'd2) begin errors++; $display("FAIL bad_stats got loaded=%b err=%b sum=%h cnt=%0d want 0 1 44 2", bus.rom_loaded, bus.load_error, bus.rom_checksum, bus.byte_count); end
        for (int i = 0; i < 300; i++) begin
            if (bus.cpu_reset_req !== 1'b1 || bus.rom_loaded !== 1'b0) bad = 1;
            tick();
        end
        checks++; if (bad) begin errors++; $display("FAIL bad_stays_reset got req=%b loaded=%b want 1 0", bus.cpu_reset_req, bus.rom_loaded); end
        bus.cpu_mreq_n = 1'b0; bus.cpu_rd_n = 1'b0; bus.cpu_addr = 16'h0042;
        #1;
        checks++; if (bus.mem_rden !== 1'b1 || bus.mem_addr !== 14'h0042) begin errors++; $display("FAIL bad_idle_read got rden=%b addr=%h want 1 0042", bus.mem_rden, bus.mem_addr); end
        bus.cpu_mreq_n = 1'b1; bus.cpu_rd_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_load();
        bus.dio_download = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.dio_write = 1'b1; bus.dio_addr = 25'(i + 16); bus.dio_data = 8'(i + 1);
            tick();
        end
        checks++; if (bus.byte_count !== 16'd5 || bus.rom_checksum !== 8'h0F) begin errors++; $display("FAIL midload_stats got cnt=%0d sum=%h want 5 0f", bus.byte_count, bus.rom_checksum); end
        bus.dio_addr = 25'd12300; bus.dio_data = 8'h77;
        reset = 1'b1;
        tick();
        checks++;
        if (bus.mem_wren !== 1'b0 || bus.mem_rden !== 1'b0 || bus.cpu_reset_req !== 1'b1 || bus.rom_loaded !== 1'b0 ||
            bus.load_error !== 1'b0 || bus.byte_count !== 16'd0 || bus.rom_checksum !== 8'd0) begin
            errors++;
            $display("FAIL midload_reset got wren=%b rden=%b req=%b loaded=%b err=%b cnt=%0d sum=%h want 0 0 1 0 0 0 00",
                     bus.mem_wren, bus.mem_rden, bus.cpu_reset_req, bus.rom_loaded, bus.load_error, bus.byte_count, bus.rom_checksum);
        end
        bus.dio_write = 1'b0; bus.dio_download = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    initial begin
        bus.dio_download = 1'b0; bus.dio_write = 1'b0; bus.dio_addr = '0; bus.dio_data = '0;
        bus.cpu_mreq_n = 1'b1; bus.cpu_rd_n = 1'b1; bus.cpu_addr = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        test_reset();
        test_back_to_back();
        test_cpu_read();
        test_drain_write();
        test_hold_reentry();
        test_bad_addr();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
